// File: rtl/spi_master2_pkg.sv
// Shared types and sizing for the MAX7219 SPI frame transmitter.
package spi_master2_pkg;

    localparam int unsigned DEF_WORD_W = 16;
    localparam int unsigned FRAME_W    = 2 * DEF_WORD_W;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : spi_master2_pkg

// File: rtl/spi_master2.sv
// Continuous write-only SPI transmitter for a MAX7219 chain: LOAD -> SHIFT x FRAME -> DONE,
// clocked on the falling edge of sck so the slave samples mosi on the rising edge.
module spi_master2
    import spi_master2_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] data,
    output logic              finish,
    output logic              mosi,
    output logic              cs
);

    localparam int unsigned FRM_W = 2 * WORD_W;
    localparam int unsigned CNT_W = $clog2(FRM_W);

    state_t             state;
    state_t             state_next;
    logic [FRM_W-1:0]   shreg;
    logic [FRM_W-1:0]   shift_next;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               cs_next;
    logic               mosi_next;
    logic               finish_next;

    assign last_bit = (cnt == CNT_W'(FRM_W - 1));

    // Frame presented to the line next cycle: fresh capture out of LOAD, else shift left.
    assign shift_next = (state == ST_LOAD) ? {address, data} : (shreg << 1);

    // State, datapath and registered outputs; rst_n is an active-high synchronous reset.
    always_ff @(negedge sck) begin
        if (rst_n) begin
            state  <= ST_LOAD;
            shreg  <= '0;
            cnt    <= '0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
            finish <= 1'b0;
        end else begin
            state  <= state_next;
            cs     <= cs_next;
            mosi   <= mosi_next;
            finish <= finish_next;
            case (state)
                ST_LOAD: begin
                    shreg <= shift_next;
                    cnt   <= '0;
                end
                ST_SHIFT: begin
                    shreg <= shift_next;
                    if (!last_bit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_LOAD;
            default:  state_next = ST_LOAD;
        endcase
    end

    // Output values for the state being entered, so registered outputs track the state.
    always_comb begin
        cs_next     = 1'b1;
        mosi_next   = 1'b0;
        finish_next = 1'b0;
        case (state_next)
            ST_SHIFT: begin
                cs_next   = 1'b0;
                mosi_next = shift_next[FRM_W-1];
            end
            ST_DONE:  finish_next = 1'b1;
            default: ;
        endcase
    end

endmodule : spi_master2

// File: tb/tb_spi_master2.sv
// Directed bench for spi_master2: reset hold, continuous frames, mid-frame input change
// and mid-frame reset, with a rising-edge receiver rebuilding each frame.
module tb_spi_master2;
    import spi_master2_pkg::*;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned PERIOD = FRAME_W + 2;

    logic              sck;
    logic              rst_n;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] data;
    logic              finish;
    logic              mosi;
    logic              cs;

    int checks   = 0;
    int failures = 0;
    int nfin;

    spi_master2 #(.WORD_W(WORD_W)) dut (
        .sck     (sck),
        .rst_n   (rst_n),
        .address (address),
        .data    (data),
        .finish  (finish),
        .mosi    (mosi),
        .cs      (cs)
    );

    // Starts high so the first event is a falling (active) edge.
    initial sck = 1'b1;
    always #5 sck = ~sck;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Runs ncyc sampled cycles after a reset release; cycle c=1 is the first SHIFT bit.
    // data is switched to 16'hFFFF right after cycle chg_at (0 = never).
    task automatic run(input int ncyc, input int chg_at, output int fins);
        logic [31:0] expf;
        logic [31:0] rx;
        int p;
        fins = 0;
        expf = '0;
        rx   = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge sck);
            p = (c - 1) % PERIOD;
            if (p == 0) expf = {address, data};
            if (finish === 1'b1) fins++;
            if (p < FRAME_W) begin
                check("cs_low", 32'(cs), 32'd0);
                check("mosi_bit", 32'(mosi), 32'(expf[FRAME_W-1-p]));
                check("finish_idle", 32'(finish), 32'd0);
                if (cs === 1'b0) rx = {rx[30:0], mosi};
            end else begin
                check("cs_high", 32'(cs), 32'd1);
                check("mosi_gap", 32'(mosi), 32'd0);
                check("finish_gap", 32'(finish), (p == FRAME_W) ? 32'd1 : 32'd0);
                if (p == FRAME_W) check("frame_rx", rx, expf);
            end
            if (c == chg_at) data = 16'hFFFF;
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        address = 16'hAAAA;
        data    = 16'h0A0A;

        for (int i = 0; i < 4; i++) begin
            @(posedge sck);
            check("rst_cs", 32'(cs), 32'd1);
            check("rst_mosi", 32'(mosi), 32'd0);
            check("rst_finish", 32'(finish), 32'd0);
        end

        // Two full frames plus part of a third; data changes at bit 20 of frame 1.
        rst_n = 1'b0;
        run(82, 21, nfin);
        check("fin_count_b2b", 32'(nfin), 32'd2);

        // Reset while the third frame is in flight.
        rst_n = 1'b1;
        @(posedge sck);
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        @(posedge sck);
        check("abort_hold_cs", 32'(cs), 32'd1);

        // Restart, then abort at bit 10.
        rst_n = 1'b0;
        run(11, 0, nfin);
        check("fin_before_abort", 32'(nfin), 32'd0);
        rst_n = 1'b1;
        @(posedge sck);
        check("mid_rst_cs", 32'(cs), 32'd1);
        check("mid_rst_mosi", 32'(mosi), 32'd0);
        check("mid_rst_finish", 32'(finish), 32'd0);

        // Full new frame from fresh inputs after release.
        address = 16'h1234;
        data    = 16'h8001;
        rst_n   = 1'b0;
        run(PERIOD, 0, nfin);
        check("fin_after_restart", 32'(nfin), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_master2

// File: doc/spi_master2.md
Name: spi_master2

Overview:
- Write-only SPI transmitter for a MAX7219 display driver chain.
- Serialises one 32-bit frame {address, data} MSB-first on mosi, framed by an active-low chip select.
- Signals frame completion with a one-cycle finish pulse.
- Runs directly from the serial clock, which is also routed to the slave's CLK pin. Restarts automatically so the display is refreshed continuously.

Parameters:
- WORD_W, 16, width of the address and data words; frame length is 2*WORD_W bits.

Ports:
- sck  input  1  serial clock; also the slave's CLK. All flops update on its falling edge.
- rst_n  input  1  synchronous reset, active-high despite the suffix; sampled on falling edge of sck.
- address  input  WORD_W  first (upper) word of the frame.
- data  input  WORD_W  second (lower) word of the frame.
- finish  output  1  one-cycle pulse marking frame end.
- mosi  output  1  serial data out.
- cs  output  1  chip select / LOAD, active-low.

Behaviour:
- Clocking: all state, mosi and cs change on the falling edge of sck. The slave therefore samples mosi on the rising edge with half a period of setup and hold.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset (rst_n=1 at a falling edge):
  - state=LOAD, cs=1, mosi=0, finish=0.
  - Shift register and bit counter cleared.
  - Reset wins over any other event, including mid-frame; a partial frame is abandoned with cs forced high.
- States:
  - LOAD (1 cycle): cs=1, mosi=0, finish=0. Captures {address, data} into a 2*WORD_W shift register. Goes to SHIFT.
  - SHIFT (2*WORD_W cycles): cs=0; mosi = shift_reg MSB, starting with address[WORD_W-1] and ending with data[0]. Shift left one bit per cycle; counter runs 0..2*WORD_W-1. After the last bit goes to DONE.
  - DONE (1 cycle): cs=1 (rising cs latches the MAX7219), finish=1, mosi=0. Goes to LOAD.
- Frame period: 2*WORD_W+2 = 34 sck cycles.
- cs high time between frames: 2 cycles (DONE + LOAD).
- address/data are sampled only in LOAD; changes during SHIFT or DONE do not affect the frame in progress.
- finish is high exactly one cycle per completed frame; never asserted for an aborted (reset) frame.
- Counter wrap: it must not run past 2*WORD_W-1; it clears in LOAD.
- mosi is 0 whenever cs=1.

Decomposition:
- Shared package: state enum (LOAD, SHIFT, DONE) and FRAME_W = 2*WORD_W.
- No sub-module needed; a single FSM with shift register and counter.

Test Plan:
- Reset hold: rst_n=1 for 4 cycles -> cs=1, mosi=0, finish=0 throughout.
- Basic frame: address=16'hAAAA, data=16'h0A0A, release reset -> one LOAD cycle with cs=1. Then cs=0 for 32 cycles with mosi = 1010101010101010 0000101000001010. Then cs=1 with finish=1 for one cycle.
- Back-to-back: keep running 82 cycles -> second identical frame starts 34 cycles after the first. Exactly two finish pulses, each 1 cycle, within the window.
- Input change mid-frame: set data=16'hFFFF at bit 20 of frame 1 -> frame 1 still ends ...0A0A. Frame 2 carries AAAAFFFF.
- Reset mid-frame: assert rst_n at bit 10 -> next falling edge cs=1, mosi=0, no finish pulse. After release, a full new frame starts from address[15].
- Sampling check: a model capturing mosi on sck rising edges while cs=0 reconstructs 32'hAAAA0A0A exactly.
